// File: rtl/ddr3_req_arbiter_if.sv
// Request bus between N READ/WRITE request sources, the arbiter and the
// single FSM request port.
//
// Handshake: a source raises ch_req_i[c] with ch_wr_i/ch_lst_i/ch_tid_i/
// ch_adr_i stable and holds it until ch_ack_o[c] or ch_err_o[c] is seen
// high at a rising clock edge; that edge completes the transfer. On the FSM
// side mem_wrreq_o/mem_rdreq_o act as valid and mem_wrack_i/mem_rdack_i
// (or the matching *err_i) act as ready; a response of the other type is
// not a completion and is ignored.
interface ddr3_req_arbiter_if #(
  parameter int CHANNELS = 3,
  parameter int ADDRS    = 28,
  parameter int REQID    = 4,
  parameter int CBITS    = $clog2(CHANNELS),
  parameter int TAGW     = REQID + CBITS
);
  logic [CHANNELS-1:0]       ch_req_i;
  logic [CHANNELS-1:0]       ch_wr_i;
  logic [CHANNELS-1:0]       ch_lst_i;
  logic [CHANNELS*REQID-1:0] ch_tid_i;
  logic [CHANNELS*ADDRS-1:0] ch_adr_i;
  logic [CHANNELS-1:0]       ch_ack_o;
  logic [CHANNELS-1:0]       ch_err_o;
  logic                      mem_wrreq_o;
  logic                      mem_rdreq_o;
  logic                      mem_lst_o;
  logic [TAGW-1:0]           mem_tid_o;
  logic [ADDRS-1:0]          mem_adr_o;
  logic                      mem_wrack_i;
  logic                      mem_wrerr_i;
  logic                      mem_rdack_i;
  logic                      mem_rderr_i;

  // Arbiter side.
  modport slave (
    input  ch_req_i, ch_wr_i, ch_lst_i, ch_tid_i, ch_adr_i,
    input  mem_wrack_i, mem_wrerr_i, mem_rdack_i, mem_rderr_i,
    output ch_ack_o, ch_err_o,
    output mem_wrreq_o, mem_rdreq_o, mem_lst_o, mem_tid_o, mem_adr_o
  );

  // Request sources plus FSM side.
  modport master (
    output ch_req_i, ch_wr_i, ch_lst_i, ch_tid_i, ch_adr_i,
    output mem_wrack_i, mem_wrerr_i, mem_rdack_i, mem_rderr_i,
    input  ch_ack_o, ch_err_o,
    input  mem_wrreq_o, mem_rdreq_o, mem_lst_o, mem_tid_o, mem_adr_o
  );
endinterface

// File: rtl/ddr3_req_arbiter.sv
// N-channel READ/WRITE request arbiter in front of the ddr3_fsm request port.
// IDLE picks a winner (round-robin or fixed priority) and registers it; LOCK
// forwards the granted channel combinationally and keeps it until a
// completion carrying lst, an error, or the burst limit with others waiting.
// gnt_vld_o mirrors the FSM state (1 = LOCK) for observation.
module ddr3_req_arbiter #(
  parameter int CHANNELS  = 3,
  parameter int ADDRS     = 28,
  parameter int REQID     = 4,
  parameter int MODE      = 0,
  parameter int MAX_BURST = 8,
  parameter int CBITS     = $clog2(CHANNELS)
) (
  input  logic                 clock,
  input  logic                 arst_n,
  ddr3_req_arbiter_if.slave    bus,
  output logic                 gnt_vld_o,
  output logic [CBITS-1:0]     gnt_idx_o
);
  localparam int CNTW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CBITS:0] CH_N = (CBITS + 1)'(CHANNELS);

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t            r_state;
  logic [CBITS-1:0]  r_ptr;
  logic [CNTW-1:0]   r_cnt;

  logic [CBITS:0]    w_sum;
  logic [CBITS-1:0]  w_idx;
  logic [CBITS-1:0]  w_win;
  logic              w_any;
  logic              w_lock;
  logic              w_g_req;
  logic              w_wr;
  logic              w_lst;
  logic [REQID-1:0]  w_tid;
  logic [ADDRS-1:0]  w_adr;
  logic              w_hit_ack;
  logic              w_hit_err;
  logic              w_acc;
  logic [CHANNELS-1:0] w_gmask;
  logic              w_others;
  logic              w_limit;
  logic              w_release;
  logic [CBITS-1:0]  w_next_ptr;

  // Winner search: scan offsets high to low so the smallest offset from the
  // start point (RR pointer, or 0 for fixed priority) is the one kept.
  always_comb begin
    w_sum = '0;
    w_idx = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (MODE == 0) begin
        w_sum = {1'b0, r_ptr} + (CBITS + 1)'(i);
        if (w_sum >= CH_N) w_sum = w_sum - CH_N;
        w_idx = w_sum[CBITS-1:0];
      end else begin
        w_idx = CBITS'(i);
      end
      if (bus.ch_req_i[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  // Forwarding from the granted channel and completion / release decode.
  always_comb begin
    w_lock    = (r_state == S_LOCK);
    w_g_req   = bus.ch_req_i[gnt_idx_o];
    w_wr      = bus.ch_wr_i[gnt_idx_o];
    w_lst     = bus.ch_lst_i[gnt_idx_o];
    w_tid     = bus.ch_tid_i[gnt_idx_o*REQID +: REQID];
    w_adr     = bus.ch_adr_i[gnt_idx_o*ADDRS +: ADDRS];
    // Responses of the type not being forwarded do not count.
    w_hit_ack = w_lock & ((bus.mem_wrack_i & w_wr) | (bus.mem_rdack_i & ~w_wr));
    w_hit_err = w_lock & ((bus.mem_wrerr_i & w_wr) | (bus.mem_rderr_i & ~w_wr));
    w_acc     = w_hit_ack | w_hit_err;
    w_gmask   = CHANNELS'(1) << gnt_idx_o;
    w_others  = |(bus.ch_req_i & ~w_gmask);
    // Counter holds the accepts already taken, so this accept is the last
    // one allowed when counter+1 reaches the limit.
    w_limit   = (MAX_BURST != 0) && ((int'(r_cnt) + 1) == MAX_BURST);
    w_release = w_acc & (w_lst | w_hit_err | (w_limit & w_others));
    w_next_ptr = (gnt_idx_o == CBITS'(CHANNELS - 1)) ? '0 : gnt_idx_o + CBITS'(1);

    bus.mem_wrreq_o = w_lock & w_g_req & w_wr;
    bus.mem_rdreq_o = w_lock & w_g_req & ~w_wr;
    bus.mem_lst_o   = w_lock & w_lst;
    bus.mem_tid_o   = w_lock ? {gnt_idx_o, w_tid} : '0;
    bus.mem_adr_o   = w_lock ? w_adr : '0;
    bus.ch_ack_o    = '0;
    bus.ch_err_o    = '0;
    bus.ch_ack_o[gnt_idx_o] = w_hit_ack;
    bus.ch_err_o[gnt_idx_o] = w_hit_err;
  end

  // Grant FSM: register the winner in IDLE, count accepts and release in LOCK.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= S_IDLE;
      gnt_vld_o <= 1'b0;
      gnt_idx_o <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state   <= S_LOCK;
            gnt_vld_o <= 1'b1;
            gnt_idx_o <= w_win;
            r_cnt     <= '0;
          end
        end
        S_LOCK: begin
          if (w_acc && (r_cnt != CNTW'(MAX_BURST))) r_cnt <= r_cnt + CNTW'(1);
          if (w_release) begin
            r_state   <= S_IDLE;
            gnt_vld_o <= 1'b0;
            if (MODE == 0) r_ptr <= w_next_ptr;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          gnt_vld_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
